ripemd_block_packer: RTL and testbench
======================================

RIPEMD_BLOCK_PACKER -- requirements
Module: ripemd_block_packer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 55, giving the largest accepted message length in bytes; legal range 1..55.
REQ-002 SHALL have clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n, input, 1 bit: the reset, asynchronous, active-low.
REQ-004 SHALL have in_valid, input, 1 bit: the input byte is valid.
REQ-005 SHALL have in_ready, output, 1 bit: the packer accepts a byte this cycle.
REQ-006 SHALL have in_data, input, 8 bits: the message byte, in stream order.
REQ-007 SHALL have in_last, input, 1 bit: marks the final byte of a message; every message carries at least 1 byte.
REQ-008 SHALL have o_valid, output, 1 bit: the padded block is presented.
REQ-009 SHALL have o_ready, input, 1 bit: the downstream RIPEMD-160 core takes the block.
REQ-010 SHALL have block, output, 512 bits: the padded block; block[511:480] is word X[0] and block[31:0] is word X[15].
REQ-011 SHALL have err, output, 1 bit: a one-cycle pulse flagging an oversize message that was discarded.

Function
REQ-012 A byte transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-013 Byte index k SHALL run 0..63 within the block; word X[i] = {byte[4i+3], byte[4i+2], byte[4i+1], byte[4i]} (little-endian).
REQ-014 There SHALL be four states: COLLECT, PAD, EMIT, DROP; reset enters COLLECT with a 6-bit byte count of 0.
REQ-015 In COLLECT: in_ready = 1; each transfer writes byte[count] = in_data and increments count.
REQ-016 In COLLECT, a transfer with in_last = 1 SHALL go to PAD; the message length L is count+1.
REQ-017 In COLLECT, a transfer with in_last = 0 when count = MAX_BYTES-1 SHALL go to DROP; this condition means the message exceeds MAX_BYTES.
REQ-018 In PAD (one cycle, in_ready = 0): byte[L] = 0x80; bytes L+1..55 = 0x00; bytes 56..63 = 64-bit little-endian value 8*L; then go to EMIT.
REQ-019 In EMIT: o_valid = 1 and in_ready = 0; block SHALL stay stable until o_ready = 1.
REQ-020 In EMIT, when o_ready = 1 the block is taken that cycle; the packer SHALL clear count and all bytes to 0 and return to COLLECT next cycle.
REQ-021 Latency: o_valid SHALL rise exactly 2 cycles after the edge on which the in_last byte is accepted.
REQ-022 Throughput limit: at most one block per message; a new message is accepted only after the previous block is taken.
REQ-023 In DROP: in_ready = 1; bytes are discarded; no block is emitted.
REQ-024 In DROP, on accepting a byte with in_last = 1, err SHALL pulse for 1 cycle (the next cycle); count and bytes clear; the FSM returns to COLLECT.
REQ-025 o_valid and err SHALL never both be 1.
REQ-026 in_data SHALL be ignored whenever no transfer occurs.
REQ-027 A cycle with in_valid = 0 in COLLECT or DROP SHALL leave all state unchanged.

Reset
REQ-028 On rst_n low, immediately and independent of clk: state = COLLECT; count = 0; block = 0; o_valid = 0; err = 0; in_ready = 0 while rst_n is low.
REQ-029 in_ready SHALL be 1 from the first rising edge after rst_n deasserts.
REQ-030 A reset asserted mid-message or during EMIT SHALL discard the partial message or pending block; no o_valid follows.

Verification
REQ-031 Send 32 bytes 0x00..0x1F with in_last on 0x1F, o_ready = 1 -> expected block:
  - X[0] = 0x03020100, X[7] = 0x1F1E1D1C
  - X[8] = 0x00000080, X[9..13] = 0
  - X[14] = 0x00000100, X[15] = 0
  - o_valid high for 1 cycle, 2 cycles after the last byte.
REQ-032 Send 1 byte 0x61 with in_last -> expected X[0] = 0x00008061, X[14] = 0x00000008, all other words 0.
REQ-033 Send 55 bytes 0x01 -> expected X[13] = 0x80010101, X[14] = 0x000001B8, X[15] = 0.
REQ-034 Send 60 bytes, in_last on the 60th -> expected: no o_valid; err pulses once, 1 cycle after the 60th byte; the next 1-byte message packs correctly.
REQ-035 Backpressure: hold o_ready low 5 cycles in EMIT -> o_valid stays 1, block unchanged, in_ready 0; block taken on the 6th cycle, then COLLECT.
REQ-036 Reset: assert rst_n low after 10 bytes of a message -> all outputs 0 at once; a following 2-byte message 0xAA,0xBB gives X[0] = 0x0080BBAA and X[14] = 0x00000010.

Source files
------------

// File: rtl/ripemd_block_packer.sv
// Packs a byte stream (1..MAX_BYTES per message) into one padded 512-bit RIPEMD-160 block.
// Block is presented two cycles after the last byte; oversize messages are dropped and flagged on err.
module ripemd_block_packer #(
  parameter int MAX_BYTES = 55
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [511:0] block,
  output logic         err
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PAD     = 2'd1,
    EMIT    = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(MAX_BYTES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  count;
  logic [7:0]  msg [64];
  logic        ready_en;
  logic        xfer;
  logic [8:0]  bit_len;

  assign xfer    = in_valid && in_ready;
  assign bit_len = {count, 3'b000};

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (xfer) begin
          if (in_last)                state_nxt = PAD;
          else if (count == LAST_IDX) state_nxt = DROP;
        end
      end
      PAD:     state_nxt = EMIT;
      EMIT:    if (o_ready) state_nxt = COLLECT;
      DROP:    if (xfer && in_last) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    o_valid  = 1'b0;
    case (state)
      COLLECT: in_ready = ready_en;
      DROP:    in_ready = ready_en;
      EMIT:    o_valid  = 1'b1;
      default: ;
    endcase
  end

  // In PAD, count already equals the message length L.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 6'd0;
      err   <= 1'b0;
      for (int k = 0; k < 64; k++) msg[k] <= 8'h00;
    end else begin
      err <= (state == DROP) && xfer && in_last;
      case (state)
        COLLECT: begin
          if (xfer) begin
            msg[count] <= in_data;
            count      <= count + 6'd1;
          end
        end
        PAD: begin
          for (int k = 0; k < 64; k++) begin
            if (k == int'(count))                   msg[k] <= 8'h80;
            else if (k > int'(count) && k < 56)     msg[k] <= 8'h00;
            else if (k == 56)                       msg[k] <= bit_len[7:0];
            else if (k == 57)                       msg[k] <= {7'd0, bit_len[8]};
            else if (k > 57)                        msg[k] <= 8'h00;
          end
        end
        EMIT: begin
          if (o_ready) begin
            count <= 6'd0;
            for (int k = 0; k < 64; k++) msg[k] <= 8'h00;
          end
        end
        DROP: begin
          if (xfer && in_last) begin
            count <= 6'd0;
            for (int k = 0; k < 64; k++) msg[k] <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  // Word X[w] is little-endian over bytes 4w..4w+3; X[0] sits in the top bits.
  always_comb begin
    block = '0;
    for (int w = 0; w < 16; w++) begin
      block[511-32*w -: 32] = {msg[4*w+3], msg[4*w+2], msg[4*w+1], msg[4*w]};
    end
  end

endmodule

// File: tb/tb_ripemd_block_packer.sv
// Scoreboard bench for ripemd_block_packer: expected blocks are queued as messages are sent.
module tb_ripemd_block_packer;

  localparam int MAX_BYTES = 55;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         o_valid;
  logic         o_ready;
  logic [511:0] block;
  logic         err;

  int checks = 0;
  int errors = 0;
  int taken_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  logic [7:0]   tb_msg [64];
  logic [511:0] exp_q [$];

  ripemd_block_packer #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .block    (block),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid && o_ready) taken_cnt++;
    if (err) err_cnt++;
    if (o_valid && err) both_cnt++;
  end

  function automatic logic [31:0] xw(input logic [511:0] b, input int i);
    return b[511-32*i -: 32];
  endfunction

  // Reference padding: message, 0x80, zeros, then 64-bit little-endian bit length.
  function automatic logic [511:0] pad_model(input int len);
    logic [7:0]   b [64];
    logic [63:0]  bits;
    logic [511:0] r;
    bits = 64'(len) * 64'd8;
    for (int k = 0; k < 64; k++) b[k] = 8'h00;
    for (int k = 0; k < len; k++) b[k] = tb_msg[k];
    b[len] = 8'h80;
    for (int j = 0; j < 8; j++) b[56+j] = bits[8*j +: 8];
    r = '0;
    for (int w = 0; w < 16; w++) r[511-32*w -: 32] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
    return r;
  endfunction

  // Leaves time at 1 unit after the edge that accepted the final byte.
  task automatic send_msg(input int len, input bit with_last);
    int w;
    if (with_last && len <= MAX_BYTES) exp_q.push_back(pad_model(len));
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = tb_msg[i];
      in_last  = with_last && (i == len - 1);
      w = 0;
      while (!in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      checks++;
      if (!in_ready) begin
        errors++;
        $display("FAIL send_ready byte %0d in_ready=%b want 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic recv_block(input string name, output logic [511:0] got);
    int n;
    logic [511:0] e;
    n = 0;
    got = '0;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!o_valid) begin
      errors++;
      $display("FAIL %s_timeout o_valid=%b want 1", name, o_valid);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected o_valid=%b want 0", name, o_valid);
    end else begin
      e = exp_q.pop_front();
      got = block;
      checks++;
      if (block !== e) begin
        errors++;
        $display("FAIL %s_block got=%h want=%h", name, block, e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; o_ready = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    checks++; if (o_valid !== 1'b0)  begin errors++; $display("FAIL rst_o_valid got=%b want=0", o_valid); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL rst_err got=%b want=0", err); end
    checks++; if (block !== '0)      begin errors++; $display("FAIL rst_block got=%h want=0", block); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0]  ew [16];
    logic [511:0] got;
    ew = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
           32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C,
           32'h00000080, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
           32'h00000100, 32'h0};
    o_ready = 1'b1;
    for (int i = 0; i < 32; i++) tb_msg[i] = 8'(i);
    send_msg(32, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_pad_cycle o_valid=%b want=0", o_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_pad_ready in_ready=%b want=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_latency o_valid=%b want=1", o_valid); end
    recv_block("basic", got);
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (xw(block, w) !== ew[w]) begin
        errors++; $display("FAIL basic_X%0d got=%h want=%h", w, xw(block, w), ew[w]);
      end
    end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle o_valid=%b want=0", o_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_collect in_ready=%b want=1", in_ready); end
  endtask

  task automatic test_one_byte(input string name);
    logic [511:0] got;
    tb_msg[0] = 8'h61;
    send_msg(1, 1'b1);
    recv_block(name, got);
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (xw(block, w) !== (w == 0 ? 32'h00008061 : (w == 14 ? 32'h00000008 : 32'h0))) begin
        errors++; $display("FAIL %s_X%0d got=%h", name, w, xw(block, w));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_len();
    logic [511:0] got;
    for (int i = 0; i < 55; i++) tb_msg[i] = 8'h01;
    send_msg(55, 1'b1);
    recv_block("max", got);
    checks++; if (xw(block, 13) !== 32'h80010101) begin errors++; $display("FAIL max_X13 got=%h want=80010101", xw(block, 13)); end
    checks++; if (xw(block, 14) !== 32'h000001B8) begin errors++; $display("FAIL max_X14 got=%h want=000001b8", xw(block, 14)); end
    checks++; if (xw(block, 15) !== 32'h0)        begin errors++; $display("FAIL max_X15 got=%h want=0", xw(block, 15)); end
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    int t0, e0;
    t0 = taken_cnt; e0 = err_cnt;
    for (int i = 0; i < 60; i++) tb_msg[i] = 8'(8'hC0 + i);
    send_msg(60, 1'b1);
    checks++; if (err !== 1'b1)     begin errors++; $display("FAIL drop_err_pulse err=%b want=1", err); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL drop_no_valid o_valid=%b want=0", o_valid); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL drop_err_width err=%b want=0", err); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_cnt - e0 !== 1)   begin errors++; $display("FAIL drop_err_count got=%0d want=1", err_cnt - e0); end
    checks++; if (taken_cnt - t0 !== 0) begin errors++; $display("FAIL drop_no_block got=%0d want=0", taken_cnt - t0); end
    test_one_byte("after_drop");
  endtask

  task automatic test_backpressure();
    logic [511:0] got;
    int t0;
    for (int i = 0; i < 7; i++) tb_msg[i] = 8'(8'h30 + 3 * i);
    o_ready = 1'b0;
    send_msg(7, 1'b1);
    recv_block("bp", got);
    t0 = taken_cnt;
    for (int c = 0; c < 5; c++) begin
      checks++; if (o_valid !== 1'b1)  begin errors++; $display("FAIL bp_hold_valid cyc %0d got=%b want=1", c, o_valid); end
      checks++; if (block !== got)     begin errors++; $display("FAIL bp_hold_block cyc %0d got=%h want=%h", c, block, got); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready cyc %0d got=%b want=0", c, in_ready); end
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_sixth_valid got=%b want=1", o_valid); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0)    begin errors++; $display("FAIL bp_taken_valid got=%b want=0", o_valid); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL bp_taken_ready got=%b want=1", in_ready); end
    checks++; if (taken_cnt - t0 !== 1) begin errors++; $display("FAIL bp_taken_count got=%0d want=1", taken_cnt - t0); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] got;
    int t0;
    t0 = taken_cnt;
    for (int i = 0; i < 10; i++) tb_msg[i] = 8'(8'h90 + i);
    send_msg(10, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (block !== '0)      begin errors++; $display("FAIL mid_rst_block got=%h want=0", block); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
    checks++; if (o_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_valid got=%b want=0", o_valid); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL mid_rst_err got=%b want=0", err); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (taken_cnt - t0 !== 0) begin errors++; $display("FAIL mid_rst_no_block got=%0d want=0", taken_cnt - t0); end
    tb_msg[0] = 8'hAA; tb_msg[1] = 8'hBB;
    send_msg(2, 1'b1);
    recv_block("after_rst", got);
    checks++; if (xw(block, 0) !== 32'h0080BBAA)  begin errors++; $display("FAIL after_rst_X0 got=%h want=0080bbaa", xw(block, 0)); end
    checks++; if (xw(block, 14) !== 32'h00000010) begin errors++; $display("FAIL after_rst_X14 got=%h want=00000010", xw(block, 14)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [511:0] got;
    int len;
    for (int m = 0; m < 4; m++) begin
      len = $urandom_range(1, MAX_BYTES);
      for (int i = 0; i < len; i++) tb_msg[i] = 8'($urandom);
      send_msg(len, 1'b1);
      recv_block("b2b", got);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_one_byte("one_byte");
    test_max_len();
    test_drop();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
    checks++; if (both_cnt != 0)     begin errors++; $display("FAIL valid_and_err got=%0d want=0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
